// File: rtl/sram_peek_fetcher.sv
// sram_peek_fetcher: requester side of the SRAM peek path. Takes a batch of
// PEEK_WIDTH byte addresses, issues SRAM word reads, steers the comparator
// with the matching peek vectors and gathers the returned bytes per lane.
// Optional macro FETCH_COALESCE_EN: one read serves every pending lane that
// lives in the same SRAM word (default build: one read per masked lane).
module sram_peek_fetcher #(
  parameter int SRAM_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PEEK_WIDTH = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_req_valid,
  output logic                                   o_req_ready,
  input  logic [PEEK_WIDTH-1:0][ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [PEEK_WIDTH-1:0]                  i_req_mask,
  output logic                                   o_sram_en,
  output logic [ADDR_WIDTH-1:0]                  o_sram_addr,
  output logic                                   o_cmp_en,
  output logic [ADDR_WIDTH-1:0]                  o_cmp_addr,
  output logic [PEEK_WIDTH-1:0][ADDR_WIDTH-1:0]  o_peek_addr,
  output logic [PEEK_WIDTH-1:0]                  o_peek_valid,
  input  logic [PEEK_WIDTH-1:0]                  i_addr_hit,
  input  logic [PEEK_WIDTH-1:0][DATA_WIDTH-1:0]  i_data_hit,
  output logic                                   o_resp_valid,
  input  logic                                   i_resp_ready,
  output logic [PEEK_WIDTH-1:0][DATA_WIDTH-1:0]  o_resp_data,
  output logic                                   o_busy
);

  localparam int BPW = SRAM_WIDTH / DATA_WIDTH;
  localparam int WSH = $clog2(BPW);
  localparam int LW  = (PEEK_WIDTH > 1) ? $clog2(PEEK_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                                state_r, state_s;
  logic [PEEK_WIDTH-1:0][ADDR_WIDTH-1:0] addr_r;
  logic [PEEK_WIDTH-1:0]                 pending_r, pending_s;
  logic [PEEK_WIDTH-1:0]                 issued_r, issued_s;
  logic [PEEK_WIDTH-1:0]                 cover_s, unissued_s, hit_s;
  logic [PEEK_WIDTH-1:0][DATA_WIDTH-1:0] data_r, data_s;
  logic                                  sram_en_s;
  logic [ADDR_WIDTH-1:0]                 sram_addr_s;
  logic                                  cmp_en_r;
  logic [ADDR_WIDTH-1:0]                 cmp_addr_r;
  logic [PEEK_WIDTH-1:0]                 peek_valid_r;
  logic [LW-1:0]                         lead_s;
  logic                                  found_s;

  // SRAM word address holding byte address a, zero-extended to ADDR_WIDTH
  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return a >> WSH;
  endfunction

  assign unissued_s = pending_r & ~issued_r;
  // Only pending lanes accept comparator data; late hits on filled lanes are dropped
  assign hit_s      = i_addr_hit & pending_r & {PEEK_WIDTH{cmp_en_r}};

  // Pick the lowest pending lane that has not been read yet
  always_comb begin
    lead_s  = '0;
    found_s = 1'b0;
    for (int i = PEEK_WIDTH - 1; i >= 0; i--) begin
      if (unissued_s[i]) begin
        lead_s  = LW'(i);
        found_s = 1'b1;
      end else begin
        lead_s  = lead_s;
        found_s = found_s;
      end
    end
  end

  // Next-state, read issue and gather logic
  always_comb begin
    state_s     = state_r;
    pending_s   = pending_r;
    issued_s    = issued_r;
    data_s      = data_r;
    cover_s     = '0;
    sram_en_s   = 1'b0;
    sram_addr_s = '0;

    for (int i = 0; i < PEEK_WIDTH; i++) begin
      if (hit_s[i]) begin
        data_s[i]    = i_data_hit[i];
        pending_s[i] = 1'b0;
      end else begin
        data_s[i]    = data_s[i];
        pending_s[i] = pending_s[i];
      end
    end

    case (state_r)
      IDLE: begin
        if (i_req_valid) begin
          pending_s = i_req_mask;
          issued_s  = '0;
          data_s    = '0;
          state_s   = (i_req_mask == '0) ? RESP : ISSUE;
        end else begin
          state_s   = IDLE;
        end
      end
      ISSUE: begin
        if (found_s) begin
          sram_en_s   = 1'b1;
          sram_addr_s = word_of(addr_r[lead_s]);
`ifdef FETCH_COALESCE_EN
          for (int i = 0; i < PEEK_WIDTH; i++) begin
            if (unissued_s[i] && (word_of(addr_r[i]) == sram_addr_s)) begin
              cover_s[i] = 1'b1;
            end else begin
              cover_s[i] = 1'b0;
            end
          end
`else
          cover_s[lead_s] = 1'b1;
`endif
          issued_s = issued_r | cover_s;
          if ((unissued_s & ~cover_s) == '0) begin
            state_s = DRAIN;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      DRAIN: begin
        // Exactly one read is in flight here; a lane still pending after it
        // returns was missed by the comparator and gets fetched again
        if (pending_s == '0) begin
          state_s  = RESP;
        end else begin
          issued_s = '0;
          state_s  = ISSUE;
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, lane bookkeeping and the one-cycle comparator return pipeline
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      pending_r    <= '0;
      issued_r     <= '0;
      data_r       <= '0;
      cmp_en_r     <= 1'b0;
      cmp_addr_r   <= '0;
      peek_valid_r <= '0;
    end else begin
      state_r      <= state_s;
      pending_r    <= pending_s;
      issued_r     <= issued_s;
      data_r       <= data_s;
      cmp_en_r     <= sram_en_s;
      cmp_addr_r   <= sram_addr_s;
      peek_valid_r <= cover_s;
      if ((state_r == IDLE) && i_req_valid) begin
        addr_r <= i_req_addr;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  assign o_req_ready  = (state_r == IDLE);
  assign o_busy       = (state_r != IDLE);
  assign o_resp_valid = (state_r == RESP);
  assign o_resp_data  = data_r;
  assign o_sram_en    = sram_en_s;
  assign o_sram_addr  = sram_addr_s;
  assign o_cmp_en     = cmp_en_r;
  assign o_cmp_addr   = cmp_addr_r;
  assign o_peek_addr  = addr_r;
  assign o_peek_valid = peek_valid_r;

endmodule

// File: tb/tb_sram_peek_fetcher.sv
// Testbench for sram_peek_fetcher: byte-addressed memory plus comparator
// model around the DUT, directed scenarios followed by random requests that
// are checked against a read-list / latency / data reference model.
module tb_sram_peek_fetcher;

  logic             clk;
  logic             i_nrst;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [3:0][7:0]  i_req_addr;
  logic [3:0]       i_req_mask;
  logic             o_sram_en;
  logic [7:0]       o_sram_addr;
  logic             o_cmp_en;
  logic [7:0]       o_cmp_addr;
  logic [3:0][7:0]  o_peek_addr;
  logic [3:0]       o_peek_valid;
  logic [3:0]       i_addr_hit;
  logic [3:0][7:0]  i_data_hit;
  logic             o_resp_valid;
  logic             i_resp_ready;
  logic [3:0][7:0]  o_resp_data;
  logic             o_busy;

  logic [7:0] mem [0:255];
  int         compared;
  int         mismatched;
  int         miss_req;
  int         miss_done;
  int         miss_lane;

  sram_peek_fetcher #(
    .SRAM_WIDTH(64), .ADDR_WIDTH(8), .DATA_WIDTH(8), .PEEK_WIDTH(4)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (i_nrst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_mask   (i_req_mask),
    .o_sram_en    (o_sram_en),
    .o_sram_addr  (o_sram_addr),
    .o_cmp_en     (o_cmp_en),
    .o_cmp_addr   (o_cmp_addr),
    .o_peek_addr  (o_peek_addr),
    .o_peek_valid (o_peek_valid),
    .i_addr_hit   (i_addr_hit),
    .i_data_hit   (i_data_hit),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_data  (o_resp_data),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator + SRAM: a lane hits when its word is the one returning,
  // except for one armed forced miss on miss_lane
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      i_addr_hit[l] = o_cmp_en && o_peek_valid[l] && ((o_peek_addr[l] >> 3) == o_cmp_addr)
                      && !((miss_req != miss_done) && (l == miss_lane));
      i_data_hit[l] = mem[o_peek_addr[l]];
    end
  end

  // Consume the armed miss once the lane's word has returned
  always @(posedge clk) begin
    if ((miss_req != miss_done) && o_cmp_en && o_peek_valid[miss_lane[1:0]]) begin
      miss_done <= miss_done + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request end to end: expected reads, latency and gathered data are
  // derived from the addresses, mask and memory contents alone
  task automatic run_req(input string tag, input logic [3:0][7:0] a, input logic [3:0] m,
                         input int hold, input bit miss, input int ml);
    logic [7:0]      exp_reads[$];
    logic [7:0]      got_reads[$];
    logic [3:0][7:0] exp_d;
    logic [3:0][7:0] held;
    logic [7:0]      w;
    bit              dup;
    bit              seen;
    int              exp_lat;
    int              cyc;
    exp_reads = {};
    got_reads = {};
    for (int l = 0; l < 4; l++) begin
      exp_d[l] = m[l] ? mem[a[l]] : 8'h00;
      if (m[l]) begin
        w = a[l] >> 3;
        dup = 1'b0;
`ifdef FETCH_COALESCE_EN
        foreach (exp_reads[k]) if (exp_reads[k] == w) dup = 1'b1;
`endif
        if (!dup) exp_reads.push_back(w);
      end
    end
    if (miss) exp_reads.push_back(a[ml] >> 3);
    exp_lat = (m == 4'd0) ? 1 : exp_reads.size() + 2 + (miss ? 1 : 0);

    @(negedge clk);
    check({tag, ":ready_before"}, {63'd0, o_req_ready}, 64'd1);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_mask  = m;
    if (miss) begin
      miss_lane = ml;
      miss_req  = miss_req + 1;
    end
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      if (o_sram_en) got_reads.push_back(o_sram_addr);
      if (o_resp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ":nreads"}, 64'(got_reads.size()), 64'(exp_reads.size()));
    if (got_reads.size() == exp_reads.size()) begin
      foreach (exp_reads[k]) check({tag, ":read_addr"}, 64'(got_reads[k]), 64'(exp_reads[k]));
    end
    check({tag, ":data"}, 64'(o_resp_data), 64'(exp_d));
    check({tag, ":busy_in_resp"}, {62'd0, o_req_ready, o_busy}, 64'd1);
    held = o_resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ":held"}, {31'd0, o_resp_valid, o_req_ready, o_resp_data}, {31'd0, 1'b1, 1'b0, held});
    end
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    check({tag, ":back_idle"}, {62'd0, o_req_ready, o_resp_valid}, 64'd2);
  endtask

  initial begin
    logic [3:0][7:0] a;
    logic [3:0]      m;
    int              stray;
    int              ml;
    compared     = 0;
    mismatched   = 0;
    miss_req     = 0;
    miss_done    = 0;
    miss_lane    = 0;
    i_nrst       = 1'b0;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_req_mask   = 4'd0;
    i_resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ctrl", {59'd0, o_sram_en, o_cmp_en, o_resp_valid, o_busy, o_req_ready}, 64'd1);
    check("rst_addr", {44'd0, o_sram_addr, o_cmp_addr, o_peek_valid}, 64'd0);
    check("rst_peek", 64'(o_peek_addr), 64'd0);
    check("rst_data", 64'(o_resp_data), 64'd0);
    i_nrst = 1'b1;

    // Reset pulse in the middle of ISSUE aborts the request
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = {8'd40, 8'd30, 8'd20, 8'd10};
    i_req_mask  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    check("midrst_issuing", {63'd0, o_sram_en}, 64'd1);
    #1 i_nrst = 1'b0;
    #1;
    check("midrst_ctrl", {59'd0, o_sram_en, o_cmp_en, o_resp_valid, o_busy, o_req_ready}, 64'd1);
    check("midrst_addr", {44'd0, o_sram_addr, o_cmp_addr, o_peek_valid}, 64'd0);
    check("midrst_data", 64'(o_resp_data), 64'd0);
    @(negedge clk);
    i_nrst = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_resp_valid || o_sram_en) stray++;
    end
    check("midrst_no_emit", 64'(stray), 64'd0);

    // Directed scenarios
    run_req("T1", {8'd3, 8'd2, 8'd1, 8'd0}, 4'b1111, 0, 1'b0, 0);
    run_req("T2", {8'd13, 8'd8, 8'd7, 8'd6}, 4'b1111, 0, 1'b0, 0);
    run_req("T3", {8'd13, 8'd8, 8'd7, 8'd6}, 4'b0000, 0, 1'b0, 0);
    run_req("T4", {8'd21, 8'd9, 8'd18, 8'd4}, 4'b0101, 5, 1'b0, 0);
    run_req("T5", {8'd3, 8'd2, 8'd1, 8'd0}, 4'b1111, 0, 1'b1, 2);
    run_req("dup", {8'd9, 8'd9, 8'd9, 8'd9}, 4'b1011, 1, 1'b0, 0);

    // Random requests over a small address window so words collide often
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      for (int l = 0; l < 4; l++) a[l] = 8'($urandom_range(0, 47));
      m  = 4'($urandom);
      ml = $urandom_range(0, 3);
      run_req("rand", a, m, $urandom_range(0, 3), (t % 5 == 4) && m[ml], ml);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
